frac_lutk_ccff: RTL and testbench
=================================

// Module: frac_lutk_ccff
// PURPOSE
//  Parametrised fracturable LUT-K for the CLB fle, with its configuration-chain memory built in.
//  Mode 0 is one LUT-K. Mode 1 is two LUT-(K-1) sharing in[0:K-2].
//  Adds a shift enable, a load counter, a cfg_done flag and output gating until fully configured.
//  Sits between the fle input muxes and the fle output/FF stage; chained head->tail with neighbours.
// PARAMETERS
//  LUT_K      4   LUT input count, legal 3..6; truth table = 2**LUT_K bits
//  CHAIN_LEN  2**LUT_K+1 (+1 with parity)  derived localparam, not overridable
//  CNT_W      $clog2(CHAIN_LEN+1)          derived localparam, load counter width
// PORTS
//  prog_clk   in   1        configuration clock; all flops rising-edge
//  pReset     in   1        asynchronous, active-low reset
//  ccff_en    in   1        shift enable for the chain
//  ccff_head  in   1        serial config data in
//  cfg_clr    in   1        synchronous restart of the load counter; mem untouched
//  frac_in    in   LUT_K    LUT inputs; index = {in[K-1],...,in[0]}
//  lutk_out   out  1        full LUT-K output
//  lutk1_out  out  2        fractured LUT-(K-1) outputs [0]=lower half, [1]=upper half
//  ccff_tail  out  1        serial config data out = mem[CHAIN_LEN-1]
//  cfg_done   out  1        exactly CHAIN_LEN bits shifted since reset/clear
//  cfg_err    out  1        parity failure (0 when macro absent)
// BEHAVIOUR
//  - Reset (pReset=0, async): mem all 0, cnt=0, cfg_done=0, ccff_tail=0.
//    cfg_err=0 and all LUT outputs 0.
//  - Shift on each edge with ccff_en=1: mem[0]<=ccff_head, mem[i]<=mem[i-1]. ccff_en=0 holds mem.
//  - Map: sram[i]=mem[i] for i<2**K; mode=mem[2**K]. First bit shifted lands at mem[CHAIN_LEN-1].
//  - Counter: on a shift, cnt<=cnt+1, saturating at CHAIN_LEN. cfg_done=(cnt==CHAIN_LEN), registered.
//  - Over-shift past CHAIN_LEN: cfg_done stays 1; bits pass through to ccff_tail (chain behaviour).
//  - cfg_clr=1: cnt<=0, or cnt<=1 if ccff_en=1 in the same cycle (clear, then count this shift).
//  - Combinational LUT path, zero latency from frac_in:
//    lo=sram[{0,in[K-2:0]}], hi=sram[{1,in[K-2:0]}].
//  - mode=0: lutk_out = in[K-1] ? hi : lo; lutk1_out=2'b00.
//  - mode=1: lutk1_out={hi,lo}; lutk_out=0.
//  - Gating: if cfg_done=0 or cfg_err=1, lutk_out=0 and lutk1_out=0.
//  - Reset mid-load: immediate clear; the full CHAIN_LEN bits must be reshifted.
// CONFIGURATION
//  FRAC_LUT_CFG_PARITY_EN defined:
//   - CHAIN_LEN=2**K+2; mem[2**K+1] is the even-parity bit, shifted first.
//   - cfg_err is registered. It is set on the edge where cnt reaches CHAIN_LEN if XOR(mem[0:CHAIN_LEN-1])==1.
//   - cfg_err is cleared by reset or cfg_clr.
//  FRAC_LUT_CFG_PARITY_EN not defined:
//   - CHAIN_LEN=2**K+1; cfg_err tied 0; no parity logic.
// TESTING (LUT_K=4, no macro unless stated; CHAIN_LEN=17)
//  1 Reset: pReset=0 while driving all inputs random.
//    -> all outputs 0; release reset, 16 shifts -> cfg_done still 0, outputs 0.
//  2 Full LUT: shift mode=0 then sram[15..0]=16'h8000 (17 shifts).
//    -> cfg_done=1 after 17th edge; in=4'hF gives lutk_out=1; in=4'hE gives 0; lutk1_out=00.
//  3 Fractured: mode=1, sram=16'h0180.
//    -> in=4'h7 gives lutk1_out=2'b01; in=4'h0 gives 2'b10; lutk_out=0 throughout.
//  4 Pass-through: after 17 shifts, shift 17 more bits with pattern P.
//    -> ccff_tail reproduces first load's bits in order; cfg_done stays 1; mem holds P.
//  5 Clear/reset mid-load: cfg_clr after 5 shifts -> needs 17 more shifts.
//    cfg_clr+ccff_en together -> 16 more. pReset pulse after 9 shifts -> all zero immediately.
//  6 Parity (macro on, CHAIN_LEN=18): load with correct parity bit -> cfg_done=1, cfg_err=0.
//    Flip one bit -> cfg_err=1 and outputs gated to 0; cfg_clr clears cfg_err.

Source files
------------

// File: rtl/frac_lutk_ccff_if.sv
// Signal bundle for the fracturable LUT-K with built-in configuration chain.
// The master side drives the chain controls and LUT inputs; the slave side is the LUT.
interface frac_lutk_ccff_if #(
  parameter int LUT_K = 4
);
  logic             ccff_en;
  logic             ccff_head;
  logic             cfg_clr;
  logic [LUT_K-1:0] frac_in;
  logic             lutk_out;
  logic [1:0]       lutk1_out;
  logic             ccff_tail;
  logic             cfg_done;
  logic             cfg_err;

  modport master (
    output ccff_en, ccff_head, cfg_clr, frac_in,
    input  lutk_out, lutk1_out, ccff_tail, cfg_done, cfg_err
  );

  modport slave (
    input  ccff_en, ccff_head, cfg_clr, frac_in,
    output lutk_out, lutk1_out, ccff_tail, cfg_done, cfg_err
  );
endinterface

// File: rtl/frac_lutk_ccff.sv
// Fracturable LUT-K (one LUT-K or two LUT-(K-1)) with its serial config chain and load tracking.
// Define FRAC_LUT_CFG_PARITY_EN to add an even-parity bit at the head of the chain and cfg_err.
module frac_lutk_ccff #(
  parameter int LUT_K = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  frac_lutk_ccff_if.slave   bus
);
  localparam int SRAM_N = 2**LUT_K;
`ifdef FRAC_LUT_CFG_PARITY_EN
  localparam int CHAIN_LEN = SRAM_N + 2;
`else
  localparam int CHAIN_LEN = SRAM_N + 1;
`endif
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  logic [CHAIN_LEN-1:0] mem;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 cfg_done_q;
  logic                 cfg_err_w;

  logic [SRAM_N-1:0]    sram;
  logic                 mode;
  logic [LUT_K-2:0]     sel;
  logic                 lo;
  logic                 hi;

  // Clear wins over the count, but a shift in the clear cycle still counts as bit one.
  always_comb begin
    cnt_next = cnt;
    if (bus.cfg_clr) begin
      cnt_next = bus.ccff_en ? CNT_W'(1) : '0;
    end else if (bus.ccff_en && (cnt != CNT_FULL)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      mem        <= '0;
      cnt        <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      if (bus.ccff_en) begin
        mem <= {mem[CHAIN_LEN-2:0], bus.ccff_head};
      end
      cnt        <= cnt_next;
      cfg_done_q <= (cnt_next == CNT_FULL);
    end
  end

`ifdef FRAC_LUT_CFG_PARITY_EN
  logic cfg_err_q;
  logic par_next;
  logic load_reach;

  // Parity is judged on the chain contents as they will be after this edge.
  assign par_next   = ^{mem[CHAIN_LEN-2:0], bus.ccff_head};
  assign load_reach = bus.ccff_en && !bus.cfg_clr && (cnt == CNT_LAST);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      cfg_err_q <= 1'b0;
    end else if (bus.cfg_clr) begin
      cfg_err_q <= 1'b0;
    end else if (load_reach && par_next) begin
      cfg_err_q <= 1'b1;
    end
  end

  assign cfg_err_w = cfg_err_q;
`else
  logic unused_cnt_last;
  assign unused_cnt_last = ^CNT_LAST;
  assign cfg_err_w = 1'b0;
`endif

  assign sram = mem[SRAM_N-1:0];
  assign mode = mem[SRAM_N];
  assign sel  = bus.frac_in[LUT_K-2:0];
  assign lo   = sram[{1'b0, sel}];
  assign hi   = sram[{1'b1, sel}];

  always_comb begin
    bus.lutk_out  = 1'b0;
    bus.lutk1_out = 2'b00;
    if (cfg_done_q && !cfg_err_w) begin
      if (mode) begin
        bus.lutk1_out = {hi, lo};
      end else begin
        bus.lutk_out = bus.frac_in[LUT_K-1] ? hi : lo;
      end
    end
  end

  assign bus.ccff_tail = mem[CHAIN_LEN-1];
  assign bus.cfg_done  = cfg_done_q;
  assign bus.cfg_err   = cfg_err_w;
endmodule

// File: tb/tb_frac_lutk_ccff.sv
// Directed plus randomized bench for frac_lutk_ccff (LUT_K=4), parity-aware via FRAC_LUT_CFG_PARITY_EN.
module tb_frac_lutk_ccff;
  localparam int LUT_K  = 4;
  localparam int SRAM_N = 16;
`ifdef FRAC_LUT_CFG_PARITY_EN
  localparam int CL  = 18;
  localparam bit PAR = 1'b1;
`else
  localparam int CL  = 17;
  localparam bit PAR = 1'b0;
`endif

  logic prog_clk = 1'b0;
  logic pReset   = 1'b0;

  frac_lutk_ccff_if #(.LUT_K(LUT_K)) bus ();
  frac_lutk_ccff #(.LUT_K(LUT_K)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (bus)
  );

  always #5 prog_clk = ~prog_clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference: queue of the last CL bits shifted (newest at index 0), plain shift count.
  bit q[$];
  bit loadbits[$];
  int n_shift;
  bit m_err;

  function automatic void m_reset();
    q.delete();
    for (int i = 0; i < CL; i++) q.push_back(1'b0);
    n_shift = 0;
    m_err   = 1'b0;
  endfunction

  function automatic void m_clock(bit en, bit head, bit clr);
    bit reach;
    bit p;
    reach = en && !clr && (n_shift == CL - 1);
    if (en) begin
      q.push_front(head);
      void'(q.pop_back());
    end
    if (clr) begin
      n_shift = en ? 1 : 0;
      m_err   = 1'b0;
    end else if (en) begin
      n_shift++;
    end
    if (reach && PAR) begin
      p = 1'b0;
      foreach (q[i]) p ^= q[i];
      if (p) m_err = 1'b1;
    end
  endfunction

  // Returns {lutk1_out, lutk_out}.
  function automatic logic [2:0] m_lut(logic [3:0] in);
    int tt;
    int idx;
    bit lo, hi;
    tt = 0;
    for (int i = 0; i < SRAM_N; i++) if (q[i]) tt |= (1 << i);
    if (n_shift < CL || m_err) return 3'b000;
    idx = in % (SRAM_N / 2);
    lo  = ((tt >> idx) & 1) != 0;
    hi  = ((tt >> (idx + SRAM_N / 2)) & 1) != 0;
    if (q[SRAM_N]) return {hi, lo, 1'b0};
    return {2'b00, (in >= SRAM_N / 2) ? hi : lo};
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit en, bit head, bit clr);
    bus.ccff_en   = en;
    bus.ccff_head = head;
    bus.cfg_clr   = clr;
    @(posedge prog_clk);
    m_clock(en, head, clr);
    #1;
    bus.ccff_en   = 1'b0;
    bus.cfg_clr   = 1'b0;
    bus.ccff_head = 1'($urandom);
  endtask

  task automatic chk_state(string tag);
    chk({tag, "_done"}, bus.cfg_done, (n_shift >= CL));
    chk({tag, "_tail"}, bus.ccff_tail, q[CL-1]);
    chk({tag, "_err"}, bus.cfg_err, m_err);
  endtask

  task automatic chk_lut(string tag, logic [3:0] in);
    logic [2:0] e;
    bus.frac_in = in;
    #1;
    e = m_lut(in);
    chk({tag, "_lutk"}, bus.lutk_out, e[0]);
    chk({tag, "_lutk1"}, bus.lutk1_out, e[2:1]);
  endtask

  task automatic load(bit mode, logic [15:0] tt, bit par_ok);
    cyc(1'b0, 1'b0, 1'b1);
    loadbits.delete();
    if (PAR) loadbits.push_back((^{mode, tt}) ^ !par_ok);
    loadbits.push_back(mode);
    for (int i = 15; i >= 0; i--) loadbits.push_back(tt[i]);
    foreach (loadbits[i]) cyc(1'b1, loadbits[i], 1'b0);
  endtask

  initial begin
    logic [3:0] rin;
    bus.ccff_en   = 1'b0;
    bus.ccff_head = 1'b0;
    bus.cfg_clr   = 1'b0;
    bus.frac_in   = '0;
    m_reset();

    // 1: reset held with random activity on every input
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      bus.ccff_en   = 1'($urandom);
      bus.ccff_head = 1'($urandom);
      bus.cfg_clr   = 1'($urandom);
      bus.frac_in   = 4'($urandom);
      #1;
      chk("rst_outs", {bus.lutk_out, bus.lutk1_out, bus.ccff_tail, bus.cfg_done, bus.cfg_err}, 8'h00);
    end
    @(negedge prog_clk);
    bus.ccff_en = 1'b0;
    bus.cfg_clr = 1'b0;
    pReset = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'($urandom), 1'b0);
    chk("rst16_done", bus.cfg_done, 1'b0);
    rin = 4'($urandom);
    bus.frac_in = rin;
    #1;
    chk("rst16_outs", {bus.lutk_out, bus.lutk1_out}, 8'h00);

    // 2: full LUT-4 as AND4
    load(1'b0, 16'h8000, 1'b1);
    chk("full_done", bus.cfg_done, 1'b1);
    bus.frac_in = 4'hF; #1;
    chk("full_F", bus.lutk_out, 1'b1);
    chk("full_F_l1", bus.lutk1_out, 2'b00);
    bus.frac_in = 4'hE; #1;
    chk("full_E", bus.lutk_out, 1'b0);

    // 3: fractured pair
    load(1'b1, 16'h0180, 1'b1);
    bus.frac_in = 4'h7; #1;
    chk("frac_7", bus.lutk1_out, 2'b01);
    chk("frac_7_lk", bus.lutk_out, 1'b0);
    bus.frac_in = 4'h0; #1;
    chk("frac_0", bus.lutk1_out, 2'b10);
    chk("frac_0_lk", bus.lutk_out, 1'b0);

    // 4: over-shift replays the previous load on the tail
    for (int j = 0; j < CL; j++) begin
      chk("pass_tail", bus.ccff_tail, loadbits[j]);
      cyc(1'b1, 1'($urandom), 1'b0);
      chk("pass_done", bus.cfg_done, 1'b1);
    end
    for (int i = 0; i < 4; i++) chk_lut("pass_lut", 4'($urandom));

    // 5: clear and reset mid-load
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < CL - 1; i++) cyc(1'b1, 1'($urandom), 1'b0);
    chk("clr_short", bus.cfg_done, 1'b0);
    cyc(1'b1, 1'($urandom), 1'b0);
    chk("clr_full", bus.cfg_done, 1'b1);
    cyc(1'b1, 1'($urandom), 1'b1);
    for (int i = 0; i < CL - 2; i++) cyc(1'b1, 1'($urandom), 1'b0);
    chk("clren_short", bus.cfg_done, 1'b0);
    cyc(1'b1, 1'($urandom), 1'b0);
    chk("clren_full", bus.cfg_done, 1'b1);
    chk_state("clren");
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0);
    pReset = 1'b0;
    #1;
    m_reset();
    chk("prst_outs", {bus.lutk_out, bus.lutk1_out, bus.ccff_tail, bus.cfg_done, bus.cfg_err}, 8'h00);
    #1;
    pReset = 1'b1;
    for (int i = 0; i < CL - 1; i++) cyc(1'b1, 1'($urandom), 1'b0);
    chk("prst_short", bus.cfg_done, 1'b0);
    cyc(1'b1, 1'($urandom), 1'b0);
    chk("prst_full", bus.cfg_done, 1'b1);

`ifdef FRAC_LUT_CFG_PARITY_EN
    // 6: parity good, parity bad, clear of the error
    load(1'b0, 16'h8000, 1'b1);
    chk("par_ok_done", bus.cfg_done, 1'b1);
    chk("par_ok_err", bus.cfg_err, 1'b0);
    load(1'b0, 16'h8000, 1'b0);
    chk("par_bad_err", bus.cfg_err, 1'b1);
    bus.frac_in = 4'hF; #1;
    chk("par_bad_gate", bus.lutk_out, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("par_clr_err", bus.cfg_err, 1'b0);
`endif

    // 7: random loads, random traffic, checked against the queue model
    for (int k = 0; k < 20; k++) begin
      load(1'($urandom), 16'($urandom), ($urandom % 4) != 0);
      chk_state("rnd_load");
      for (int i = 0; i < 6; i++) chk_lut("rnd_lut", 4'($urandom));
      for (int i = 0; i < 4; i++) begin
        cyc(1'($urandom), 1'($urandom), ($urandom % 8) == 0);
        chk_state("rnd_cyc");
        chk_lut("rnd_cyc", 4'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
